// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, instruction classification and address-counter helpers
// for the HD44780-compatible display responder.
package lcd_hd44780_pkg;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam int         LINE_LEN    = 40;
  localparam logic [6:0] IDX_NONE    = 7'h7f;
  localparam logic [6:0] LINE0_LAST  = 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE1_LAST  = LINE1_BASE + 7'(LINE_LEN - 1);

  typedef enum logic [3:0] {
    INS_NOP,
    INS_CLEAR,
    INS_HOME,
    INS_ENTRY,
    INS_DISPLAY,
    INS_SHIFT,
    INS_FUNC,
    INS_CGRAM,
    INS_DDRAM
  } instr_e;

  localparam logic [7:0] MASK_DDRAM   = 8'h80, CMP_DDRAM   = 8'h80;
  localparam logic [7:0] MASK_CGRAM   = 8'hc0, CMP_CGRAM   = 8'h40;
  localparam logic [7:0] MASK_FUNC    = 8'he0, CMP_FUNC    = 8'h20;
  localparam logic [7:0] MASK_SHIFT   = 8'hf0, CMP_SHIFT   = 8'h10;
  localparam logic [7:0] MASK_DISPLAY = 8'hf8, CMP_DISPLAY = 8'h08;
  localparam logic [7:0] MASK_ENTRY   = 8'hfc, CMP_ENTRY   = 8'h04;
  localparam logic [7:0] MASK_HOME    = 8'hfe, CMP_HOME    = 8'h02;
  localparam logic [7:0] MASK_CLEAR   = 8'hff, CMP_CLEAR   = 8'h01;

  // The highest set bit selects the instruction class.
  function automatic instr_e decode_instr(input logic [7:0] ir);
    instr_e cls;
    if ((ir & MASK_DDRAM) == CMP_DDRAM)          cls = INS_DDRAM;
    else if ((ir & MASK_CGRAM) == CMP_CGRAM)     cls = INS_CGRAM;
    else if ((ir & MASK_FUNC) == CMP_FUNC)       cls = INS_FUNC;
    else if ((ir & MASK_SHIFT) == CMP_SHIFT)     cls = INS_SHIFT;
    else if ((ir & MASK_DISPLAY) == CMP_DISPLAY) cls = INS_DISPLAY;
    else if ((ir & MASK_ENTRY) == CMP_ENTRY)     cls = INS_ENTRY;
    else if ((ir & MASK_HOME) == CMP_HOME)       cls = INS_HOME;
    else if ((ir & MASK_CLEAR) == CMP_CLEAR)     cls = INS_CLEAR;
    else                                         cls = INS_NOP;
    return cls;
  endfunction

  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    logic [6:0] idx;
    idx = IDX_NONE;
    if (ac < 7'(LINE_LEN))
      idx = ac;
    else if (ac >= LINE1_BASE && ac <= LINE1_LAST)
      idx = ac - LINE1_BASE + 7'(LINE_LEN);
    return idx;
  endfunction

  // Mapped addresses wrap between the two lines; unmapped ones step mod 128.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] nxt;
    if (up) begin
      if (ac == LINE0_LAST)      nxt = LINE1_BASE;
      else if (ac == LINE1_LAST) nxt = 7'h00;
      else                       nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)           nxt = LINE1_LAST;
      else if (ac == LINE1_BASE) nxt = LINE0_LAST;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_ddram_dp.sv
// 80x8 display RAM: port A writes and reads for the bus side, port B is a
// read-only port for the renderer. Reads return pre-write data.
module lcd_ddram_dp
  import lcd_hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       a_we,
  input  logic [6:0] a_waddr,
  input  logic [7:0] a_wdata,
  input  logic [6:0] a_raddr,
  output logic [7:0] a_rdata,
  input  logic [6:0] b_addr,
  output logic [7:0] b_rdata
);

  logic [7:0] mem [0:DDRAM_DEPTH-1];
  logic [7:0] a_rdata_reg;
  logic [7:0] b_rdata_reg;

  // Indices past the array read as zero so nothing undefined reaches the pads.
  always_ff @(posedge clk) begin
    if (a_we && a_waddr < 7'(DDRAM_DEPTH))
      mem[a_waddr] <= a_wdata;
    a_rdata_reg <= (a_raddr < 7'(DDRAM_DEPTH)) ? mem[a_raddr] : 8'h00;
    b_rdata_reg <= (b_addr < 7'(DDRAM_DEPTH)) ? mem[b_addr] : 8'h00;
  end

  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side HD44780 bus responder: synchronizes the host strobe, decodes
// instructions and data writes on the falling edge, and serves bus reads.
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_SHORT  = 1850,
  parameter int BUSY_LONG   = 76000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_data_in,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] cursor_idx,
  output logic       busy,
  output logic       overrun_err
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  logic [SYNC_STAGES-1:0] e_sync_reg;
  logic                   e_prev_reg;
  logic                   rs_cap_reg, rw_cap_reg;
  logic [7:0]             data_cap_reg;

  logic [6:0]    ac_reg, ac_next;
  logic          inc_reg, inc_next;
  logic          disp_on_reg, disp_on_next;
  logic          cursor_on_reg, cursor_on_next;
  logic          blink_on_reg, blink_on_next;
  logic          overrun_reg, overrun_next;
  logic [CW-1:0] busy_cnt_reg, busy_cnt_next;
  logic          fill_active_reg, fill_active_next;
  logic [6:0]    fill_idx_reg, fill_idx_next;

  logic       e_synced, e_fall;
  logic [6:0] ac_idx;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  instr_e     instr;

  assign e_synced = e_sync_reg[SYNC_STAGES-1];
  assign e_fall   = e_prev_reg & ~e_synced;
  assign ac_idx   = ac_to_idx(ac_reg);
  assign busy     = (busy_cnt_reg != '0);

  lcd_ddram_dp u_ddram (
    .clk     (clk),
    .a_we    (ram_we),
    .a_waddr (ram_waddr),
    .a_wdata (ram_wdata),
    .a_raddr (ac_idx),
    .a_rdata (ram_rdata),
    .b_addr  (disp_addr),
    .b_rdata (disp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      e_sync_reg      <= '0;
      e_prev_reg      <= 1'b0;
      rs_cap_reg      <= 1'b0;
      rw_cap_reg      <= 1'b0;
      data_cap_reg    <= 8'h00;
      ac_reg          <= 7'h00;
      inc_reg         <= 1'b1;
      disp_on_reg     <= 1'b0;
      cursor_on_reg   <= 1'b0;
      blink_on_reg    <= 1'b0;
      overrun_reg     <= 1'b0;
      busy_cnt_reg    <= CW'(BUSY_LONG);
      fill_active_reg <= 1'b1;
      fill_idx_reg    <= 7'h00;
    end else begin
      e_sync_reg      <= {e_sync_reg[SYNC_STAGES-2:0], LCD_E};
      e_prev_reg      <= e_synced;
      // Keep sampling while the strobe is high; the last sample is committed.
      if (e_synced) begin
        rs_cap_reg   <= LCD_RS;
        rw_cap_reg   <= LCD_RW;
        data_cap_reg <= LCD_data_in;
      end
      ac_reg          <= ac_next;
      inc_reg         <= inc_next;
      disp_on_reg     <= disp_on_next;
      cursor_on_reg   <= cursor_on_next;
      blink_on_reg    <= blink_on_next;
      overrun_reg     <= overrun_next;
      busy_cnt_reg    <= busy_cnt_next;
      fill_active_reg <= fill_active_next;
      fill_idx_reg    <= fill_idx_next;
    end
  end

  always_comb begin
    ac_next          = ac_reg;
    inc_next         = inc_reg;
    disp_on_next     = disp_on_reg;
    cursor_on_next   = cursor_on_reg;
    blink_on_next    = blink_on_reg;
    overrun_next     = overrun_reg;
    busy_cnt_next    = busy ? busy_cnt_reg - CW'(1) : busy_cnt_reg;
    fill_active_next = fill_active_reg;
    fill_idx_next    = fill_idx_reg;
    ram_we           = 1'b0;
    ram_waddr        = ac_idx;
    ram_wdata        = data_cap_reg;
    instr            = decode_instr(data_cap_reg);

    // The clear fill always runs inside a busy window, so it never meets a bus write.
    if (fill_active_reg) begin
      ram_we    = 1'b1;
      ram_waddr = fill_idx_reg;
      ram_wdata = CHAR_SPACE;
      if (fill_idx_reg == 7'(DDRAM_DEPTH - 1))
        fill_active_next = 1'b0;
      else
        fill_idx_next = fill_idx_reg + 7'd1;
    end

    if (e_fall) begin
      if (rw_cap_reg) begin
        if (rs_cap_reg)
          ac_next = ac_step(ac_reg, inc_reg);
      end else if (busy) begin
        overrun_next = 1'b1;
      end else if (rs_cap_reg) begin
        ram_we        = (ac_idx != IDX_NONE);
        ac_next       = ac_step(ac_reg, inc_reg);
        busy_cnt_next = CW'(BUSY_SHORT);
      end else begin
        busy_cnt_next = CW'(BUSY_SHORT);
        case (instr)
          INS_DDRAM:   ac_next = data_cap_reg[6:0];
          INS_SHIFT:   if (!data_cap_reg[3]) ac_next = ac_step(ac_reg, data_cap_reg[2]);
          INS_DISPLAY: begin
            disp_on_next   = data_cap_reg[2];
            cursor_on_next = data_cap_reg[1];
            blink_on_next  = data_cap_reg[0];
          end
          INS_ENTRY:   inc_next = data_cap_reg[1];
          INS_HOME: begin
            ac_next       = 7'h00;
            busy_cnt_next = CW'(BUSY_LONG);
          end
          INS_CLEAR: begin
            ac_next          = 7'h00;
            inc_next         = 1'b1;
            fill_active_next = 1'b1;
            fill_idx_next    = 7'h00;
            busy_cnt_next    = CW'(BUSY_LONG);
          end
          INS_NOP:     busy_cnt_next = busy ? busy_cnt_reg - CW'(1) : busy_cnt_reg;
          default:     ;
        endcase
      end
    end
  end

  // Read path follows the pad pins directly so status is driven as soon as E syncs.
  assign LCD_data_oe  = e_synced & LCD_RW;
  assign LCD_data_out = !LCD_data_oe ? 8'h00 : (LCD_RS ? ram_rdata : {busy, ac_reg});

  assign disp_on     = disp_on_reg;
  assign cursor_on   = cursor_on_reg;
  assign blink_on    = blink_on_reg;
  assign overrun_err = overrun_reg;
  assign cursor_idx  = ac_idx;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed and randomized bench for lcd_hd44780_responder with a
// linear-address reference model of the display RAM and address counter.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_data_in;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [6:0] disp_addr;
  logic [7:0] disp_data;
  logic       disp_on, cursor_on, blink_on;
  logic [6:0] cursor_idx;
  logic       busy, overrun_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [0:79];
  int         m_ac;
  bit         m_inc;
  bit         m_d, m_c, m_b;

  lcd_hd44780_responder #(
    .BUSY_SHORT(4), .BUSY_LONG(100), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_data_in(LCD_data_in), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .cursor_idx(cursor_idx),
    .busy(busy), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Two-line display seen as one 80-cell ring; anything else is outside it.
  function automatic int m_idx(input int ac);
    if (ac < 40) return ac;
    if (ac >= 64 && ac < 104) return ac - 24;
    return 127;
  endfunction

  function automatic int m_step(input int ac, input bit up);
    int i;
    i = m_idx(ac);
    if (i == 127) return up ? (ac + 1) % 128 : (ac + 127) % 128;
    i = up ? (i + 1) % 80 : (i + 79) % 80;
    return (i < 40) ? i : i + 24;
  endfunction

  // Called and returns on a falling clock edge: 8-clk strobe, 4-clk hold.
  task automatic bus(input bit rs, input bit rw, input logic [7:0] d,
                     output logic [7:0] rd, output bit seen, output logic [7:0] first);
    LCD_RS = rs; LCD_RW = rw; LCD_data_in = d; LCD_E = 1'b1;
    seen = 1'b0; first = 8'h00; rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (LCD_data_oe && !seen) begin
        seen = 1'b1;
        first = LCD_data_out;
      end
      rd = LCD_data_out;
    end
    LCD_E = 1'b0;
    repeat (4) @(negedge clk);
    $display("bus rs=%0d rw=%0d din=%02h dout=%02h", rs, rw, d, rd);
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    logic [7:0] rd, first;
    bit seen;
    bus(rs, 1'b0, d, rd, seen, first);
  endtask

  task automatic rd_bus(input bit rs, output logic [7:0] rd);
    logic [7:0] first;
    bit seen;
    bus(rs, 1'b1, 8'h00, rd, seen, first);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic peek(input int idx, output logic [7:0] v);
    disp_addr = 7'(idx);
    @(negedge clk);
    v = disp_data;
  endtask

  initial begin
    logic [7:0] v, rd, first;
    bit seen;
    int n, op, a;
    logic [7:0] d;

    LCD_E = 0; LCD_RS = 0; LCD_RW = 0; LCD_data_in = 0; disp_addr = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", LCD_data_out, 0);
    chk("rst_oe", LCD_data_oe, 0);
    chk("rst_disp_on", {disp_on, cursor_on, blink_on}, 0);
    chk("rst_overrun", overrun_err, 0);
    reset = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_busy_cycles", n, 100);
    peek(5, v);  chk("rst_idx5", v, 8'h20);
    peek(79, v); chk("rst_idx79", v, 8'h20);
    chk("rst_cursor", cursor_idx, 0);

    // Line wrap 0x27 -> 0x40 on data writes.
    wr(0, 8'ha7); wait_idle(n);
    wr(1, 8'h41); wait_idle(n);
    wr(1, 8'h42); wait_idle(n);
    peek(39, v); chk("wrap_idx39", v, 8'h41);
    peek(40, v); chk("wrap_idx40", v, 8'h42);
    rd_bus(0, rd); chk("wrap_status", rd, 8'h41);
    chk("wrap_cursor", cursor_idx, 41);
    rd_bus(1, rd); chk("data_read", rd, 8'h20);
    rd_bus(0, rd); chk("read_steps_ac", rd, 8'h42);

    // Status read right behind a command sees busy.
    wr(0, 8'h0c);
    bus(0, 1'b1, 8'h00, rd, seen, first);
    chk("busy_oe_seen", seen, 1);
    chk("busy_status_b7", first[7], 1);
    wait_idle(n);
    chk("dcb_after_0c", {disp_on, cursor_on, blink_on}, 3'b100);

    // Write landing inside a busy window is dropped.
    wr(0, 8'h02);
    wr(1, 8'h99);
    chk("overrun_set", overrun_err, 1);
    wait_idle(n);
    peek(0, v);  chk("dropped_idx0", v, 8'h20);
    peek(42, v); chk("dropped_idx42", v, 8'h20);
    rd_bus(0, rd); chk("home_status", rd, 8'h00);

    // Decrement wrap 0x40 -> 0x27.
    wr(0, 8'h04); wait_idle(n);
    wr(0, 8'hc0); wait_idle(n);
    wr(1, 8'h58); wait_idle(n);
    peek(40, v); chk("dec_idx40", v, 8'h58);
    rd_bus(0, rd); chk("dec_status", rd, 8'h27);
    wr(1, 8'h59); wait_idle(n);
    peek(39, v); chk("dec_idx39", v, 8'h59);
    chk("dec_cursor", cursor_idx, 38);
    chk("overrun_sticky", overrun_err, 1);

    // Clear after populating more cells.
    wr(1, 8'h61); wait_idle(n);
    wr(1, 8'h62); wait_idle(n);
    wr(0, 8'h01);
    chk("clear_busy", busy, 1);
    wait_idle(n);
    chk("clear_busy_window", (n >= 95 && n <= 100), 1);
    for (int i = 0; i < 80; i++) begin
      peek(i, v);
      chk($sformatf("clear_idx%0d", i), v, 8'h20);
    end
    rd_bus(0, rd); chk("clear_status", rd, 8'h00);
    wr(1, 8'h4d); wait_idle(n);
    peek(0, v); chk("clear_inc_idx0", v, 8'h4d);
    chk("clear_inc_cursor", cursor_idx, 1);

    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    m_mem[0] = 8'h4d; m_ac = 1; m_inc = 1; m_d = 1; m_c = 0; m_b = 0;

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1: begin
          d = 8'($urandom);
          wr(1, d);
          if (m_idx(m_ac) != 127) m_mem[m_idx(m_ac)] = d;
          m_ac = m_step(m_ac, m_inc);
        end
        2: begin
          if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 127);
          else begin
            a = $urandom_range(0, 79);
            if (a >= 40) a = a + 24;
          end
          wr(0, 8'h80 | 8'(a));
          m_ac = a;
        end
        3: begin
          m_inc = 1'($urandom);
          wr(0, 8'h04 | {6'b0, m_inc, 1'($urandom)});
        end
        4: begin
          {m_d, m_c, m_b} = 3'($urandom);
          wr(0, {5'b00001, m_d, m_c, m_b});
        end
        5: begin
          a = $urandom_range(0, 15);
          wr(0, 8'h10 | 8'(a));
          if (a < 8) m_ac = m_step(m_ac, a[2]);
        end
        default: begin
          if (m_idx(m_ac) != 127) begin
            rd_bus(1, rd);
            chk("rand_data_read", rd, m_mem[m_idx(m_ac)]);
            m_ac = m_step(m_ac, m_inc);
          end else begin
            rd_bus(0, rd);
            chk("rand_status", rd, m_ac);
          end
        end
      endcase
      wait_idle(n);
      chk("rand_cursor", cursor_idx, m_idx(m_ac));
    end
    rd_bus(0, rd); chk("rand_final_ac", rd, m_ac);
    chk("rand_dcb", {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b});
    for (int i = 0; i < 80; i++) begin
      peek(i, v);
      chk($sformatf("rand_idx%0d", i), v, m_mem[i]);
    end

    chk("overrun_held", overrun_err, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_overrun", overrun_err, 0);
    chk("rst2_disp_on", disp_on, 0);
    chk("rst2_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Device-side HD44780-compatible character LCD responder. It is the display end of the LCD_E/LCD_RS/LCD_RW/LCD_data bus driven by the host-side LCD Avalon slave.
- Decodes instructions and data writes into an 80-byte DDRAM, address counter (AC) and display-control state.
- Returns busy flag, AC and DDRAM data on bus reads.
- Exposes a registered DDRAM read port for a downstream character renderer (VGA text overlay).

Parameters:
- BUSY_SHORT, 1850: busy cycles after a normal instruction or data write (37 us at 50 MHz).
- BUSY_LONG, 76000: busy cycles after clear, return-home and reset (1.52 ms); must be >= 80.
- SYNC_STAGES, 2: synchronizer depth for the asynchronous bus inputs.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- LCD_E  in  1  enable strobe; asynchronous to clk
- LCD_RS  in  1  0 = instruction/status, 1 = data
- LCD_RW  in  1  0 = write, 1 = read
- LCD_data_in  in  8  bus data from the pad
- LCD_data_out  out  8  read data to the pad
- LCD_data_oe  out  1  pad output enable
- disp_addr  in  7  renderer physical DDRAM index, 0..79
- disp_data  out  8  DDRAM[disp_addr], 1-cycle latency
- disp_on  out  1  display enable (D bit)
- cursor_on  out  1  C bit
- blink_on  out  1  B bit
- cursor_idx  out  7  physical index of AC; 127 when AC is unmapped
- busy  out  1  busy flag
- overrun_err  out  1  sticky: a write arrived while busy

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Input sync: LCD_E passes through SYNC_STAGES flops.
  - While synced E = 1: RS, RW and data are re-captured every cycle.
  - Commit happens on the synced E falling edge, using the last captured values.
  - Host timing constraint: data hold after E falls >= SYNC_STAGES+1 clk.
- Reset values: LCD_data_out = 0, LCD_data_oe = 0, disp_on = 0, cursor_on = 0, blink_on = 0, overrun_err = 0, AC = 0, increment = 1.
- Reset also starts a clear fill with busy counter = BUSY_LONG.
  - busy = 1 from the first cycle after reset deasserts.
  - Reset mid-fill or mid-busy restarts the fill and the busy count.
- Reads (synced E = 1 and RW = 1):
  - LCD_data_oe = 1.
  - RS = 0: LCD_data_out = {busy, AC}. Allowed while busy.
  - RS = 1: LCD_data_out = DDRAM[AC], valid 1 cycle after E sync.
  - LCD_data_oe drops the cycle synced E falls.
  - A data read steps AC on the falling edge; a status read does not.
- Address map: AC 0x00-0x27 maps to index 0-39; AC 0x40-0x67 maps to index 40-79.
  - Increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
  - Decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
  - From an unmapped AC, steps are plain +/-1 mod 128.
  - Data writes to an unmapped AC are discarded, but AC still steps.
- Instruction decode (RS = 0, RW = 0), highest set bit wins:
  - 1aaaaaaa: AC = aaaaaaa.
  - 01xxxxxx: CGRAM address; accepted, no effect.
  - 001xxxxx: function set; accepted, no effect.
  - 0001 S R xx: S = 0 moves AC +1 (R = 1) or -1 (R = 0); S = 1 has no effect.
  - 00001DCB: load disp_on, cursor_on, blink_on.
  - 000001 I S: increment = I; S is ignored.
  - 0000001x: AC = 0; BUSY_LONG.
  - 00000001: clear. Writes 0x20 to indices 0..79, one per cycle (80 cycles); AC = 0, increment = 1; BUSY_LONG.
  - 00000000: no-op, no busy.
  - All other accepted instructions and data writes load BUSY_SHORT.
- Data write (RS = 1, RW = 0): DDRAM[AC] = data, then AC steps in the increment direction.
- Busy handling: busy = (counter != 0); the counter decrements each cycle.
  - A write committed while busy is dropped and sets overrun_err.
  - Reads while busy are served normally.
- Simultaneous events: a renderer read at the same index as a write in the same cycle returns the old data.
  - Renderer reads during a clear fill return either old data or 0x20.

Decomposition:
- lcd_hd44780_pkg:
  - instruction-class mask and compare constants
  - CHAR_SPACE = 8'h20
  - DDRAM_DEPTH = 80
  - LINE1_BASE = 7'h40
  - LINE_LEN = 40
  - AC-to-index and AC-step functions
- Sub-module lcd_ddram_dp: 80x8 RAM.
  - Port A: write plus registered read, bus side.
  - Port B: registered read, renderer.

Test Plan (BUSY_SHORT = 4, BUSY_LONG = 100, SYNC_STAGES = 2, E pulses 8 clk with 4-clk hold):
- Reset 3 cycles -> busy = 1 for 100 cycles, then 0; disp_data at index 5 and index 79 = 0x20; cursor_idx = 0.
- Cmd 0xA7, then data 0x41 and 0x42 -> index 39 = 0x41, index 40 = 0x42; status read returns 0x41 with bit7 = 0.
- Cmd 0x0C, then immediate status read -> LCD_data_out[7] = 1 and LCD_data_oe = 1 during E; after busy clears, disp_on = 1, cursor_on = 0.
- Data write issued 1 cycle after a prior command -> DDRAM unchanged, overrun_err = 1 and stays 1 until reset.
- Cmd 0x04, cmd 0xC0, data 0x58 -> index 40 = 0x58, AC = 0x27; a further data write lands at index 39.
- Fill several cells, then cmd 0x01 -> busy for 100 cycles; all 80 indices = 0x20; AC = 0; next data write goes to index 0 and AC = 1.
